// File: rtl/asm_frame_sync.sv
// Marker correlator with flywheel lock; unpacks MSB-first payload bytes one cycle after the 8th bit, no backpressure.
// Define ASM_INVERT_DETECT_EN to also lock on inverted markers and de-invert the payload that follows.
module asm_frame_sync #(
  parameter logic [31:0] ASM_WORD    = 32'h1ACFFC1D,
  parameter int          FRAME_BYTES = 1020,
  parameter int          ASM_TOL     = 3,
  parameter int          MISS_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       bit_in,
  input  logic       valid_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [2:0] miss_cnt
);

  localparam int FRAME_BITS = FRAME_BYTES * 8;
  localparam int CNT_W = ($clog2(FRAME_BITS) > 5) ? $clog2(FRAME_BITS) : 5;
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_MARK  = CNT_W'(31);
  localparam logic [CNT_W-1:0] FIRST_BYTE = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       MISS_MAX   = 3'(MISS_LIMIT);
  localparam logic [5:0]       TOL        = 6'(ASM_TOL);

  typedef enum logic [1:0] {
    SEARCH,
    DATA,
    CHECK
  } state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

  state_t           state_q;
  logic [30:0]      hist_q;
  logic [31:0]      hist_d;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       sr_q;
  logic [7:0]       byte_q;
  logic             bv_q;
  logic             fs_q;
  logic [2:0]       miss_q;

  logic hit_true;
  logic hit_search;
  logic hit_check;
  logic data_bit;

  // Only the 31 older bits are stored; the incoming bit completes the 32-bit window.
  assign hist_d   = {hist_q, bit_in};
  assign hit_true = (popcount32(hist_d ^ ASM_WORD) <= TOL);

`ifdef ASM_INVERT_DETECT_EN
  logic pol_q;
  logic hit_inv;

  assign hit_inv    = (popcount32(~hist_d ^ ASM_WORD) <= TOL);
  assign hit_search = hit_true | hit_inv;
  assign hit_check  = pol_q ? hit_inv : hit_true;
  assign data_bit   = bit_in ^ pol_q;
`else
  assign hit_search = hit_true;
  assign hit_check  = hit_true;
  assign data_bit   = bit_in;
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= SEARCH;
      hist_q  <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      fs_q    <= 1'b0;
      miss_q  <= '0;
`ifdef ASM_INVERT_DETECT_EN
      pol_q   <= 1'b0;
`endif
    end else begin
      bv_q <= 1'b0;
      fs_q <= 1'b0;
      if (valid_in) begin
        hist_q <= hist_d[30:0];
        unique case (state_q)
          SEARCH: begin
            if (hit_search) begin
              state_q <= DATA;
              cnt_q   <= '0;
              miss_q  <= '0;
              sr_q    <= '0;
`ifdef ASM_INVERT_DETECT_EN
              // True polarity wins when both correlations pass.
              pol_q   <= ~hit_true;
`endif
            end
          end
          DATA: begin
            sr_q <= {sr_q[5:0], data_bit};
            if (cnt_q[2:0] == 3'd7) begin
              byte_q <= {sr_q, data_bit};
              bv_q   <= 1'b1;
              fs_q   <= (cnt_q == FIRST_BYTE);
            end
            if (cnt_q == LAST_DATA) begin
              state_q <= CHECK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          CHECK: begin
            if (cnt_q == LAST_MARK) begin
              cnt_q   <= '0;
              state_q <= DATA;
              if (hit_check) begin
                miss_q <= '0;
              end else if ((miss_q + 3'd1) == MISS_MAX) begin
                state_q <= SEARCH;
                miss_q  <= '0;
                sr_q    <= '0;
`ifdef ASM_INVERT_DETECT_EN
                pol_q   <= 1'b0;
`endif
              end else begin
                miss_q <= miss_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign byte_out    = byte_q;
  assign byte_valid  = bv_q;
  assign frame_start = fs_q;
  assign locked      = (state_q != SEARCH);
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_asm_frame_sync.sv
// Directed bench for asm_frame_sync: lock, tolerance, flywheel, gapped valid, mid-frame reset, polarity.
module tb_asm_frame_sync;

  localparam logic [31:0] ASM = 32'h1ACFFC1D;
  localparam int          NB  = 1020;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       bit_in;
  logic       valid_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_start;
  logic       locked;
  logic [2:0] miss_cnt;

  int total = 0;
  int bad = 0;
  int gap = 0;
  int bad_timing = 0;
  logic [7:0] q_b[$];
  bit         q_f[$];

  always #5 clk = ~clk;

  asm_frame_sync dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .bit_in     (bit_in),
    .valid_in   (valid_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_start(frame_start),
    .locked     (locked),
    .miss_cnt   (miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A byte strobe is legal only right after the last bit of a payload byte.
  task automatic sample(input bit on_byte_edge);
    if (byte_valid === 1'b1) begin
      q_b.push_back(byte_out);
      q_f.push_back(frame_start);
      if (!on_byte_edge) bad_timing++;
    end else if (frame_start !== 1'b0) begin
      bad_timing++;
    end
  endtask

  task automatic send_bit(input logic b, input bit last);
    bit_in   = b;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sample(last);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      sample(1'b0);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic send_bytes(input int n, input logic [7:0] keep, input logic [7:0] xr);
    logic [7:0] v;
    for (int k = 0; k < n; k++) begin
      v = (8'(k) & keep) ^ xr;
      for (int j = 7; j >= 0; j--) send_bit(v[j], j == 0);
    end
  endtask

  // Each frame restarts its payload at 0x00, with frame_start on byte 0 only.
  task automatic verify(input string tag, input int n);
    int mism;
    mism = 0;
    check({tag, "_count"}, 32'(q_b.size()), 32'(n));
    for (int i = 0; i < q_b.size(); i++) begin
      if (q_b[i] !== 8'(i % NB)) mism++;
      if (q_f[i] !== ((i % NB) == 0)) mism++;
    end
    check({tag, "_data"}, 32'(mism), 32'd0);
    check({tag, "_timing"}, 32'(bad_timing), 32'd0);
  endtask

  task automatic clear_log();
    q_b.delete();
    q_f.delete();
    bad_timing = 0;
  endtask

  task automatic reset_dut();
    sys_rst  = 1'b1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    clear_log();
  endtask

  initial begin
    sys_rst  = 1'b1;
    valid_in = 1'b0;
    bit_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    sys_rst = 1'b0;
    clear_log();

    // Clean lock: marker, one full frame, marker.
    send_word(ASM);
    check("clean_locked_after_asm", 32'(locked), 32'd1);
    send_bytes(NB, 8'hFF, 8'h00);
    send_word(ASM);
    verify("clean", NB);
    check("clean_locked", 32'(locked), 32'd1);
    check("clean_miss_cnt", 32'(miss_cnt), 32'd0);

    // Flywheel: four frames with all-zero markers.
    clear_log();
    for (int k = 1; k <= 4; k++) begin
      send_bytes(NB, 8'hFF, 8'h00);
      send_word(32'h0);
      if (k < 4) begin
        check($sformatf("fly_miss_%0d", k), 32'(miss_cnt), 32'(k));
        check($sformatf("fly_locked_%0d", k), 32'(locked), 32'd1);
      end
    end
    check("fly_unlocked", 32'(locked), 32'd0);
    check("fly_miss_cleared", 32'(miss_cnt), 32'd0);
    verify("fly", 4 * NB);
    clear_log();
    send_bytes(16, 8'hFF, 8'h00);
    check("fly_no_output", 32'(q_b.size()), 32'd0);

    // Tolerance: 3 bit errors lock, 4 do not.
    reset_dut();
    send_word(ASM ^ 32'h8001_0001);
    check("tol3_locked", 32'(locked), 32'd1);
    send_bytes(2, 8'hFF, 8'h00);
    verify("tol3", 2);
    reset_dut();
    send_word(ASM ^ 32'h8001_0101);
    check("tol4_unlocked", 32'(locked), 32'd0);
    send_bytes(2, 8'hFF, 8'h00);
    check("tol4_no_output", 32'(q_b.size()), 32'd0);

    // Gapped valid: one valid cycle in three.
    reset_dut();
    gap = 2;
    send_word(ASM);
    send_bytes(NB, 8'hFF, 8'h00);
    send_word(ASM);
    verify("gapped", NB);
    check("gapped_locked", 32'(locked), 32'd1);
    gap = 0;

    // Reset at byte 500 aborts the frame; only a new marker reacquires.
    reset_dut();
    send_word(ASM);
    send_bytes(500, 8'hFF, 8'h00);
    verify("pre_reset", 500);
    sys_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_byte_valid", 32'(byte_valid), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_byte_out", 32'(byte_out), 32'd0);
    sys_rst = 1'b0;
    clear_log();
    send_bytes(NB - 500, 8'h00, 8'h00);
    check("midrst_no_output", 32'(q_b.size()), 32'd0);
    check("midrst_still_unlocked", 32'(locked), 32'd0);
    send_word(ASM);
    send_bytes(4, 8'hFF, 8'h00);
    verify("reacquire", 4);

`ifdef ASM_INVERT_DETECT_EN
    reset_dut();
    send_word(~ASM);
    check("inv_locked", 32'(locked), 32'd1);
    send_bytes(8, 8'hFF, 8'hFF);
    verify("inv", 8);
`else
    reset_dut();
    send_word(~ASM);
    check("inv_ignored", 32'(locked), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
